// File: rtl/clk_div_bank_pkg.sv
// Shared types and ratio helpers for the programmable clock divider bank.
package clk_div_pkg;

  localparam int unsigned MIN_RATIO = 2;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_STOP = 2'd2
  } ch_state_t;

  function automatic int unsigned eff_ratio(input int unsigned v);
    return (v < MIN_RATIO) ? MIN_RATIO : v;
  endfunction

  // Odd ratios put the extra cycle in the high phase.
  function automatic int unsigned high_len(input int unsigned r);
    return (r + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control and status bundle between the divider bank and its controller.
interface clk_div_bank_if #(
  parameter int NUM_CH  = 3,
  parameter int RATIO_W = 8
);
  logic [NUM_CH*RATIO_W-1:0] i_ratio;
  logic [NUM_CH-1:0]         i_ratio_load;
  logic [NUM_CH-1:0]         i_en;
  logic                      i_sync;
  logic [NUM_CH-1:0]         o_div_clk;
  logic [NUM_CH-1:0]         o_locked;

  modport master (output i_ratio, i_ratio_load, i_en, i_sync,
                  input  o_div_clk, o_locked);
  modport slave  (input  i_ratio, i_ratio_load, i_en, i_sync,
                  output o_div_clk, o_locked);
endinterface

// File: rtl/clk_div_bank_chan.sv
// One divider channel: run/stop FSM, period counter, pending ratio and lock flag.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] ratio_in,
  input  logic               load,
  input  logic               en,
  input  logic               sync,
  output logic               div_clk,
  output logic               locked
);

  localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(eff_ratio(32'(DEFAULT_RATIO)));

  ch_state_t          state;
  logic [RATIO_W-1:0] cnt, ratio, pend;
  logic               pend_vld;

  logic [RATIO_W-1:0] ld_ratio, nxt_ratio, nxt_cnt, hi_len;
  logic               wrap;

  always_comb begin
    ld_ratio  = RATIO_W'(eff_ratio(32'(ratio_in)));
    nxt_ratio = load ? ld_ratio : (pend_vld ? pend : ratio);
    nxt_cnt   = cnt + 1'b1;
    hi_len    = RATIO_W'(high_len(32'(ratio)));
    wrap      = (state != CH_IDLE) && (cnt == ratio - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      ratio    <= RST_RATIO;
      pend     <= '0;
      pend_vld <= 1'b0;
      div_clk  <= 1'b0;
      locked   <= 1'b0;
    end else if (state == CH_IDLE) begin
      // Idle channels take a new ratio straight away; no period is in flight.
      ratio    <= nxt_ratio;
      pend_vld <= 1'b0;
      locked   <= 1'b0;
      if (en) begin
        state   <= CH_RUN;
        cnt     <= 1;
        div_clk <= 1'b1;
      end else begin
        cnt     <= '0;
        div_clk <= 1'b0;
      end
    end else if (sync) begin
      ratio    <= nxt_ratio;
      pend_vld <= 1'b0;
      cnt      <= 1;
      div_clk  <= 1'b1;
      locked   <= 1'b0;
      state    <= en ? CH_RUN : CH_STOP;
    end else if (wrap) begin
      // Period boundary: the only place a running channel changes ratio.
      ratio    <= nxt_ratio;
      pend_vld <= 1'b0;
      cnt      <= '0;
      if (en) begin
        state   <= CH_RUN;
        div_clk <= 1'b1;
        locked  <= !load && !pend_vld;
      end else begin
        state   <= CH_IDLE;
        div_clk <= 1'b0;
        locked  <= 1'b0;
      end
    end else begin
      cnt     <= nxt_cnt;
      div_clk <= nxt_cnt < hi_len;
      state   <= en ? CH_RUN : CH_STOP;
      if (load) begin
        pend     <= ld_ratio;
        pend_vld <= 1'b1;
      end
      if (load || !en) locked <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one sync strobe.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = 10
) (
  input  logic           Ref_Clk,
  input  logic           Rst,
  clk_div_bank_if.slave  bus
);

  logic [NUM_CH-1:0][RATIO_W-1:0] ratio_v;
  logic [NUM_CH-1:0]              div_clk, locked;

  assign ratio_v = bus.i_ratio;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(
      .RATIO_W      (RATIO_W),
      .DEFAULT_RATIO(DEFAULT_RATIO)
    ) u_chan (
      .clk     (Ref_Clk),
      .rst     (Rst),
      .ratio_in(ratio_v[c]),
      .load    (bus.i_ratio_load[c]),
      .en      (bus.i_en[c]),
      .sync    (bus.i_sync),
      .div_clk (div_clk[c]),
      .locked  (locked[c])
    );
  end

  assign bus.o_div_clk = div_clk;
  assign bus.o_locked  = locked;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: hand-computed output/lock vectors edge by edge.
module tb_clk_div_bank;

  logic clk;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  clk_div_bank_if #(.NUM_CH(3), .RATIO_W(8)) bus ();

  clk_div_bank #(.NUM_CH(3), .RATIO_W(8), .DEFAULT_RATIO(10)) dut (
    .Ref_Clk(clk),
    .Rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_ratio      = '0;
    bus.i_ratio_load = '0;
    bus.i_en         = '0;
    bus.i_sync       = 1'b0;
    tick_n(2);
    chk("rst_clk", bus.o_div_clk, 3'b000);
    chk("rst_lock", bus.o_locked, 3'b000);
    rst = 1'b0;

    // Defaults on ch0/ch2, ch1 loaded to 20 while idle
    bus.i_ratio      = {8'd10, 8'd20, 8'd10};
    bus.i_ratio_load = 3'b010;
    tick();
    bus.i_ratio_load = 3'b000;
    bus.i_en         = 3'b111;
    tick();            chk("a1_clk",  bus.o_div_clk, 3'b111);
                       chk("a1_lock", bus.o_locked,  3'b000);
    tick_n(4);         chk("a5_clk",  bus.o_div_clk, 3'b010);
    tick_n(4);         chk("a9_lock", bus.o_locked,  3'b000);
    tick();            chk("a10_clk", bus.o_div_clk, 3'b101);
                       chk("a10_lock", bus.o_locked, 3'b101);
    tick_n(5);         chk("a15_clk", bus.o_div_clk, 3'b000);
    tick_n(4);         chk("a19_lock", bus.o_locked, 3'b101);
    tick();            chk("a20_clk", bus.o_div_clk, 3'b111);
                       chk("a20_lock", bus.o_locked, 3'b111);

    // Disable at cnt=2: high phase completes, period finishes, then idle
    tick_n(2);
    bus.i_en = 3'b000;
    tick();            chk("d23_clk",  bus.o_div_clk, 3'b111);
                       chk("d23_lock", bus.o_locked,  3'b000);
    tick();            chk("d24_clk",  bus.o_div_clk, 3'b111);
    tick();            chk("d25_clk",  bus.o_div_clk, 3'b010);
    tick_n(5);         chk("d30_clk",  bus.o_div_clk, 3'b000);
    tick();            chk("d31_clk",  bus.o_div_clk, 3'b000);
    tick_n(9);         chk("d40_clk",  bus.o_div_clk, 3'b000);
                       chk("d40_lock", bus.o_locked,  3'b000);

    // Odd ratio 7 on ch2, clamped ratios 0 and 1 on ch0/ch1
    bus.i_ratio      = {8'd7, 8'd1, 8'd0};
    bus.i_ratio_load = 3'b111;
    tick();
    bus.i_ratio_load = 3'b000;
    bus.i_en         = 3'b111;
    tick();            chk("b1_clk",  bus.o_div_clk, 3'b111);
                       chk("b1_lock", bus.o_locked,  3'b000);
    tick();            chk("b2_clk",  bus.o_div_clk, 3'b111);
                       chk("b2_lock", bus.o_locked,  3'b011);
    tick();            chk("b3_clk",  bus.o_div_clk, 3'b100);
    tick();            chk("b4_clk",  bus.o_div_clk, 3'b011);
    tick_n(2);         chk("b6_clk",  bus.o_div_clk, 3'b011);
    tick();            chk("b7_clk",  bus.o_div_clk, 3'b100);
                       chk("b7_lock", bus.o_locked,  3'b111);
    tick_n(3);         chk("b10_clk", bus.o_div_clk, 3'b111);
    tick();            chk("b11_clk", bus.o_div_clk, 3'b000);
    tick_n(2);         chk("b13_clk", bus.o_div_clk, 3'b000);
    tick();            chk("b14_clk", bus.o_div_clk, 3'b111);
    bus.i_en = 3'b000;
    tick_n(10);        chk("b24_clk",  bus.o_div_clk, 3'b000);
                       chk("b24_lock", bus.o_locked,  3'b000);

    // Mid-period reload on ch0 (6 then 4, last wins) at cnt=3
    bus.i_ratio      = {8'd10, 8'd20, 8'd10};
    bus.i_ratio_load = 3'b111;
    tick();
    bus.i_ratio_load = 3'b000;
    bus.i_en         = 3'b001;
    tick();            chk("c1_clk",  bus.o_div_clk, 3'b001);
    tick_n(9);         chk("c10_clk", bus.o_div_clk, 3'b001);
                       chk("c10_lock", bus.o_locked, 3'b001);
    tick_n(3);         chk("c13_lock", bus.o_locked, 3'b001);
    bus.i_ratio      = {8'd10, 8'd20, 8'd6};
    bus.i_ratio_load = 3'b001;
    tick();            chk("c14_clk",  bus.o_div_clk, 3'b001);
                       chk("c14_lock", bus.o_locked,  3'b000);
    bus.i_ratio      = {8'd10, 8'd20, 8'd4};
    tick();
    bus.i_ratio_load = 3'b000;
                       chk("c15_clk", bus.o_div_clk, 3'b000);
    tick_n(4);         chk("c19_clk", bus.o_div_clk, 3'b000);
    tick();            chk("c20_clk", bus.o_div_clk, 3'b001);
                       chk("c20_lock", bus.o_locked, 3'b000);
    tick();            chk("c21_clk", bus.o_div_clk, 3'b001);
    tick();            chk("c22_clk", bus.o_div_clk, 3'b000);
    tick();            chk("c23_clk", bus.o_div_clk, 3'b000);
                       chk("c23_lock", bus.o_locked, 3'b000);
    tick();            chk("c24_clk", bus.o_div_clk, 3'b001);
                       chk("c24_lock", bus.o_locked, 3'b001);
    tick_n(2);         chk("c26_clk", bus.o_div_clk, 3'b000);
    bus.i_en = 3'b000;
    tick_n(4);

    // Sync: ch0 (R=10) at cnt=6, ch1 (R=20) at cnt=13
    bus.i_ratio      = {8'd10, 8'd20, 8'd10};
    bus.i_ratio_load = 3'b111;
    tick();
    bus.i_ratio_load = 3'b000;
    bus.i_en         = 3'b010;
    tick_n(7);
    bus.i_en = 3'b011;
    tick_n(6);         chk("s13_clk", bus.o_div_clk, 3'b000);
    bus.i_sync = 1'b1;
    tick();
    bus.i_sync = 1'b0;
                       chk("s14_clk",  bus.o_div_clk, 3'b011);
                       chk("s14_lock", bus.o_locked,  3'b000);
    tick_n(4);         chk("s18_clk",  bus.o_div_clk, 3'b010);
    tick_n(4);         chk("s22_clk",  bus.o_div_clk, 3'b010);
                       chk("s22_lock", bus.o_locked,  3'b000);
    tick();            chk("s23_clk",  bus.o_div_clk, 3'b001);
                       chk("s23_lock", bus.o_locked,  3'b001);
    tick_n(10);        chk("s33_clk",  bus.o_div_clk, 3'b011);
                       chk("s33_lock", bus.o_locked,  3'b011);
    tick_n(19);        chk("s52_clk",  bus.o_div_clk, 3'b000);
    tick();            chk("s53_clk",  bus.o_div_clk, 3'b011);
                       chk("s53_lock", bus.o_locked,  3'b011);
    bus.i_sync = 1'b1;
    tick();
    bus.i_sync = 1'b0;
                       chk("s54_clk",  bus.o_div_clk, 3'b011);
                       chk("s54_lock", bus.o_locked,  3'b000);

    // Reset mid-high-phase with a pending ratio on ch0
    bus.i_ratio      = {8'd10, 8'd20, 8'd4};
    bus.i_ratio_load = 3'b001;
    tick();
    bus.i_ratio_load = 3'b000;
                       chk("r0_clk", bus.o_div_clk, 3'b011);
    #2;
    rst      = 1'b1;
    bus.i_en = 3'b000;
    #1;                chk("r_async_clk",  bus.o_div_clk, 3'b000);
                       chk("r_async_lock", bus.o_locked,  3'b000);
    tick_n(2);
    rst      = 1'b0;
    bus.i_en = 3'b001;
    tick();            chk("e1_clk",  bus.o_div_clk, 3'b001);
    tick();            chk("e2_clk",  bus.o_div_clk, 3'b001);
    tick_n(3);         chk("e5_clk",  bus.o_div_clk, 3'b000);
    tick_n(4);         chk("e9_lock", bus.o_locked,  3'b000);
    tick();            chk("e10_clk",  bus.o_div_clk, 3'b001);
                       chk("e10_lock", bus.o_locked,  3'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider bank for the PHY clocking path.
- Sits downstream of the frequency multiplier and replaces fixed-ratio single dividers; one instance produces the word clock (/10), PCLK (/20) and spare ratios from the 5 GHz bit-rate clock.
- Adds runtime ratio reload, per-channel glitch-free enable and disable, cross-channel phase alignment, and per-channel lock indication.

Parameters:
- NUM_CH, 3, number of independent divider channels.
- RATIO_W, 8, width of each channel's divide ratio.
- DEFAULT_RATIO, 10, active ratio of every channel after reset.

Ports:
- Ref_Clk  in  1  source clock; the only clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- i_ratio  in  NUM_CH*RATIO_W  packed ratios; channel c at bits [c*RATIO_W +: RATIO_W].
- i_ratio_load  in  NUM_CH  per-channel single-cycle strobe that captures i_ratio slice into pending.
- i_en  in  NUM_CH  per-channel run enable (level).
- i_sync  in  1  single-cycle strobe that phase-aligns all running channels.
- o_div_clk  out  NUM_CH  divided clocks, registered.
- o_locked  out  NUM_CH  channel is producing stable periods at its current ratio.

Behaviour:
- Reset (async, Rst=1):
  - state=CH_IDLE, cnt=0, active ratio R=DEFAULT_RATIO, no pending ratio.
  - o_div_clk=0, o_locked=0.
- Ratio rules:
  - Effective ratio is max(value, 2). Values 0 and 1 clamp to 2.
  - High length H=ceil(R/2), low length R-H. Odd R gives one extra high cycle.
  - Max R = 2^RATIO_W-1.
- Per-channel FSM (clk_div_chan):
  - CH_IDLE: output 0, cnt held 0. When i_en is sampled 1, apply any pending ratio, go to CH_RUN, set cnt=1, and set o_div_clk=1 on that same edge (zero-cycle start latency).
  - CH_RUN:
    - cnt counts 0..R-1. o_div_clk registered = (next cnt < H).
    - Wrap when cnt==R-1; the next edge gives cnt=0 with output high.
  - CH_RUN -> CH_STOP: when i_en is sampled 0. o_locked clears on that edge.
  - CH_STOP: continue the current period unchanged. At wrap, go to CH_IDLE with output 0. No truncated high pulse is allowed.
  - CH_STOP -> CH_RUN: if i_en returns to 1 before the wrap, continue with no glitch. Lock re-arms as described below.
- Ratio reload:
  - i_ratio_load[c] captures the slice into pending. If loaded twice before apply, the last value wins.
  - Pending is applied at the next wrap, or immediately if the channel is CH_IDLE.
  - If load and wrap occur on the same edge, the new value applies at that wrap. The period already in flight is never altered.
  - o_locked clears on the load edge.
- Lock:
  - o_locked sets on the wrap edge that completes the first full period at the active ratio with nothing pending.
  - It is cleared by: disable, load, sync, or reset.
- i_sync:
  - On the sampled edge, every channel in CH_RUN or CH_STOP applies its pending ratio, restarts at cnt=1, and drives output 1.
  - o_locked clears and relocks after one full period.
  - Channels in CH_IDLE are unaffected, except a channel whose i_en=1 on the same edge; it starts aligned with the others.
  - i_sync and a load on the same edge: the loaded value is used.
- Reset mid-operation: all channels return immediately to reset values. No output pulse completes.
- o_div_clk is a flop output, so it is glitch-free by construction. Duty cycle is exactly H/R.

Decomposition:
- Shared package clk_div_pkg:
  - MIN_RATIO=2.
  - ch_state_t enum {CH_IDLE, CH_RUN, CH_STOP}.
  - Function eff_ratio(), which clamps a value to MIN_RATIO.
  - Function high_len(), which returns ceil(R/2).
- Sub-module clk_div_chan:
  - Contains one channel's FSM, counter, pending register, and lock logic.
  - clk_div_bank generates NUM_CH instances plus i_ratio slicing.

Test Plan:
- Reset release, then i_en=3'b111 with defaults and load ch1=20 first -> ch0 period 10 (5 high/5 low), ch1 period 20; o_locked rises on the 10th and 20th edge respectively.
- Odd ratio: load ch2=7, enable -> 4 high/3 low repeating; ratios 0 and 1 -> 1 high/1 low.
- Mid-period reload: ch0 running R=10, load 4 at cnt=3 -> current period finishes at 10 cycles, then 2/2 periods; o_locked low from the load edge until 4 cycles after the switch.
- Disable at cnt=2 of R=10 -> output holds its high phase to cnt=4, low until wrap, then stays 0 in CH_IDLE; never a pulse shorter than H.
- i_sync with ch0 R=10 at cnt=6 and ch1 R=20 at cnt=13 -> both rise on the same edge, and rising edges coincide every 20 cycles thereafter.
- Assert Rst mid-high-phase -> o_div_clk and o_locked go 0 asynchronously; after release, ratio is back to 10 with the pending load discarded.
